pio_irq_ctrl: RTL and testbench

PIO_IRQ_CTRL -- requirements
Module: pio_irq_ctrl

---
 rtl/pio_irq_ctrl.sv | 142 ++++++++++++++
 tb/tb_pio_irq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_irq_ctrl.sv
// PIO IRQ flag register: per-SM set/clear requests, host write-1-to-clear and two masked interrupt lines.
// Optional macro PIO_IRQ_FORCE_EN adds the INTF0/INTF1 force registers and their load strobes.
module pio_irq_ctrl #(
  parameter int NUM_SM    = 4,
  parameter int NUM_FLAGS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SM-1:0]     sm_irq_vld,
  input  logic [NUM_SM-1:0]     sm_irq_clr,
  input  logic [NUM_SM*3-1:0]   sm_irq_idx,
  input  logic [NUM_SM-1:0]     sm_irq_rel,
  input  logic                  host_wr_irq,
  input  logic [31:0]           host_din,
  input  logic                  host_wr_inte0,
  input  logic                  host_wr_inte1,
`ifdef PIO_IRQ_FORCE_EN
  input  logic                  host_wr_intf0,
  input  logic                  host_wr_intf1,
`endif
  output logic [NUM_FLAGS-1:0]  flags,
  output logic                  irq0,
  output logic                  irq1
);

  // Relative mode rotates the two LSBs by the SM number; bit 2 selects the flag bank and is kept.
  function automatic logic [2:0] eff_idx(input logic [2:0] idx, input logic rel, input int sm);
    logic [2:0] e;
    if (rel) begin
      e = {idx[2], idx[1:0] + 2'(sm)};
    end else begin
      e = idx;
    end
    return e;
  endfunction

  function automatic logic [NUM_FLAGS-1:0] onehot(input logic [2:0] idx);
    logic [NUM_FLAGS-1:0] v;
    v = '0;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      v[f] = (int'(idx) == f);
    end
    return v;
  endfunction

  logic [NUM_FLAGS-1:0] flags_r;
  logic [NUM_FLAGS-1:0] flags_next_s;
  logic [NUM_FLAGS-1:0] set_s;
  logic [NUM_FLAGS-1:0] clr_s;
  logic [NUM_FLAGS-1:0] hit_s;
  logic [3:0]           inte0_r;
  logic [3:0]           inte1_r;
  logic [3:0]           inte0_next_s;
  logic [3:0]           inte1_next_s;
  logic                 irq0_r;
  logic                 irq1_r;
  logic                 irq0_next_s;
  logic                 irq1_next_s;
  logic                 unused_s;

`ifdef PIO_IRQ_FORCE_EN
  logic [3:0]           intf0_r;
  logic [3:0]           intf1_r;
  logic [3:0]           intf0_next_s;
  logic [3:0]           intf1_next_s;
`endif

  // Merge all SM requests and the host clear into set/clear masks; set wins over clear.
  always_comb begin
    set_s = '0;
    clr_s = host_din[NUM_FLAGS-1:0] & {NUM_FLAGS{host_wr_irq}};
    hit_s = '0;
    for (int n = 0; n < NUM_SM; n++) begin
      hit_s = onehot(eff_idx(sm_irq_idx[3*n +: 3], sm_irq_rel[n], n)) & {NUM_FLAGS{sm_irq_vld[n]}};
      set_s = set_s | (hit_s & {NUM_FLAGS{~sm_irq_clr[n]}});
      clr_s = clr_s | (hit_s & {NUM_FLAGS{sm_irq_clr[n]}});
    end
    flags_next_s = (flags_r & ~clr_s) | set_s;
  end

  // Next enable/force values and the interrupt lines they produce from the next flag state.
  always_comb begin
    if (host_wr_inte0) begin
      inte0_next_s = host_din[3:0];
    end else begin
      inte0_next_s = inte0_r;
    end
    if (host_wr_inte1) begin
      inte1_next_s = host_din[3:0];
    end else begin
      inte1_next_s = inte1_r;
    end
`ifdef PIO_IRQ_FORCE_EN
    if (host_wr_intf0) begin
      intf0_next_s = host_din[3:0];
    end else begin
      intf0_next_s = intf0_r;
    end
    if (host_wr_intf1) begin
      intf1_next_s = host_din[3:0];
    end else begin
      intf1_next_s = intf1_r;
    end
    irq0_next_s = |((flags_next_s[3:0] & inte0_next_s) | intf0_next_s);
    irq1_next_s = |((flags_next_s[3:0] & inte1_next_s) | intf1_next_s);
`else
    irq0_next_s = |(flags_next_s[3:0] & inte0_next_s);
    irq1_next_s = |(flags_next_s[3:0] & inte1_next_s);
`endif
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= '0;
      inte0_r <= 4'h0;
      inte1_r <= 4'h0;
      irq0_r  <= 1'b0;
      irq1_r  <= 1'b0;
`ifdef PIO_IRQ_FORCE_EN
      intf0_r <= 4'h0;
      intf1_r <= 4'h0;
`endif
    end else begin
      flags_r <= flags_next_s;
      inte0_r <= inte0_next_s;
      inte1_r <= inte1_next_s;
      irq0_r  <= irq0_next_s;
      irq1_r  <= irq1_next_s;
`ifdef PIO_IRQ_FORCE_EN
      intf0_r <= intf0_next_s;
      intf1_r <= intf1_next_s;
`endif
    end
  end

  assign flags    = flags_r;
  assign irq0     = irq0_r;
  assign irq1     = irq1_r;
  assign unused_s = ^host_din[31:NUM_FLAGS];

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Directed self-checking bench for pio_irq_ctrl (default NUM_SM=4, NUM_FLAGS=8).
module tb_pio_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  sm_irq_vld;
  logic [3:0]  sm_irq_clr;
  logic [11:0] sm_irq_idx;
  logic [3:0]  sm_irq_rel;
  logic        host_wr_irq;
  logic [31:0] host_din;
  logic        host_wr_inte0;
  logic        host_wr_inte1;
`ifdef PIO_IRQ_FORCE_EN
  logic        host_wr_intf0;
  logic        host_wr_intf1;
`endif
  logic [7:0]  flags;
  logic        irq0;
  logic        irq1;

  int total_cnt;
  int pass_cnt;
  int fail_cnt;

  pio_irq_ctrl #(.NUM_SM(4), .NUM_FLAGS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .sm_irq_vld    (sm_irq_vld),
    .sm_irq_clr    (sm_irq_clr),
    .sm_irq_idx    (sm_irq_idx),
    .sm_irq_rel    (sm_irq_rel),
    .host_wr_irq   (host_wr_irq),
    .host_din      (host_din),
    .host_wr_inte0 (host_wr_inte0),
    .host_wr_inte1 (host_wr_inte1),
`ifdef PIO_IRQ_FORCE_EN
    .host_wr_intf0 (host_wr_intf0),
    .host_wr_intf1 (host_wr_intf1),
`endif
    .flags         (flags),
    .irq0          (irq0),
    .irq1          (irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sm_irq_vld    = 4'h0;
    sm_irq_clr    = 4'h0;
    sm_irq_idx    = 12'h000;
    sm_irq_rel    = 4'h0;
    host_wr_irq   = 1'b0;
    host_din      = 32'h0;
    host_wr_inte0 = 1'b0;
    host_wr_inte1 = 1'b0;
`ifdef PIO_IRQ_FORCE_EN
    host_wr_intf0 = 1'b0;
    host_wr_intf1 = 1'b0;
`endif
  endtask

  // Advance one edge and land 1 time unit after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    idle();
    reset = 1'b1;
    #1;
    chk("rst_flags", {24'h0, flags}, 32'h00);
    chk("rst_irq0", {31'h0, irq0}, 32'h0);
    chk("rst_irq1", {31'h0, irq1}, 32'h0);

    // Requests during reset are discarded
    sm_irq_vld = 4'hF;
    sm_irq_idx = 12'hFAC;
    tick();
    chk("rst_discard", {24'h0, flags}, 32'h00);
    idle();
    reset = 1'b0;

    // INTE0 = 0x7; flags untouched
    host_din = 32'h7; host_wr_inte0 = 1'b1;
    tick(); idle();
    chk("inte0_flags", {24'h0, flags}, 32'h00);
    chk("inte0_irq0", {31'h0, irq0}, 32'h0);

    // SM0 idx0, SM1 idx1 together
    sm_irq_vld = 4'b0011; sm_irq_idx = 12'h008;
    tick(); idle();
    chk("set01_flags", {24'h0, flags}, 32'h03);
    chk("set01_irq0", {31'h0, irq0}, 32'h1);
    chk("set01_irq1", {31'h0, irq1}, 32'h0);

    // Host W1C bit 0 then bit 1
    host_wr_irq = 1'b1; host_din = 32'h1;
    tick(); idle();
    chk("w1c1_flags", {24'h0, flags}, 32'h02);
    chk("w1c1_irq0", {31'h0, irq0}, 32'h1);
    host_wr_irq = 1'b1; host_din = 32'h2;
    tick(); idle();
    chk("w1c2_flags", {24'h0, flags}, 32'h00);
    chk("w1c2_irq0", {31'h0, irq0}, 32'h0);

    // INTE1 = 0x8
    host_din = 32'h8; host_wr_inte1 = 1'b1;
    tick(); idle();
    chk("inte1_irq1", {31'h0, irq1}, 32'h0);

    // SM3 rel idx6 -> {1,(2+3)%4}=5; bank-high flag drives no irq
    sm_irq_vld = 4'b1000; sm_irq_rel = 4'b1000; sm_irq_idx = 12'hC00;
    tick(); idle();
    chk("rel3_flags", {24'h0, flags}, 32'h20);
    chk("rel3_irq0", {31'h0, irq0}, 32'h0);
    chk("rel3_irq1", {31'h0, irq1}, 32'h0);

    // SM2 rel idx3 -> {0,(3+2)%4}=1
    sm_irq_vld = 4'b0100; sm_irq_rel = 4'b0100; sm_irq_idx = 12'h0C0;
    tick(); idle();
    chk("rel2_flags", {24'h0, flags}, 32'h22);
    chk("rel2_irq0", {31'h0, irq0}, 32'h1);

    // Host clears everything
    host_wr_irq = 1'b1; host_din = 32'hFF;
    tick(); idle();
    chk("clrall_flags", {24'h0, flags}, 32'h00);

    // SM3 plain idx3 -> flag 3 drives irq1 only
    sm_irq_vld = 4'b1000; sm_irq_idx = 12'h600;
    tick(); idle();
    chk("f3_flags", {24'h0, flags}, 32'h08);
    chk("f3_irq0", {31'h0, irq0}, 32'h0);
    chk("f3_irq1", {31'h0, irq1}, 32'h1);

    // vld=0 ignores clr/idx/rel; host write of 0 is a no-op
    sm_irq_clr = 4'hF; sm_irq_idx = 12'h6DB; sm_irq_rel = 4'hF;
    host_wr_irq = 1'b1; host_din = 32'h0;
    tick(); idle();
    chk("novld_flags", {24'h0, flags}, 32'h08);
    chk("novld_irq1", {31'h0, irq1}, 32'h1);

    // SM1 clears idx3
    sm_irq_vld = 4'b0010; sm_irq_clr = 4'b0010; sm_irq_idx = 12'h018;
    tick(); idle();
    chk("smclr_flags", {24'h0, flags}, 32'h00);
    chk("smclr_irq1", {31'h0, irq1}, 32'h0);

    // flags=0x04, then set idx2 against a simultaneous host clear of 0x04
    sm_irq_vld = 4'b0001; sm_irq_idx = 12'h002;
    tick(); idle();
    chk("f2_flags", {24'h0, flags}, 32'h04);
    sm_irq_vld = 4'b0001; sm_irq_idx = 12'h002;
    host_wr_irq = 1'b1; host_din = 32'h04;
    tick(); idle();
    chk("setwins_flags", {24'h0, flags}, 32'h04);
    chk("setwins_irq0", {31'h0, irq0}, 32'h1);

    // SM0 idx7 and SM1 rel idx6 ({1,(2+1)%4}=7) merge; SM2 clears idx2
    sm_irq_vld = 4'b0111; sm_irq_clr = 4'b0100; sm_irq_rel = 4'b0010;
    sm_irq_idx = 12'h0B7;
    tick(); idle();
    chk("merge_flags", {24'h0, flags}, 32'h80);
    chk("merge_irq0", {31'h0, irq0}, 32'h0);

    // Fill all flags in two cycles
    sm_irq_vld = 4'hF; sm_irq_idx = 12'h688;
    tick(); idle();
    chk("fillA_flags", {24'h0, flags}, 32'h8F);
    sm_irq_vld = 4'hF; sm_irq_idx = 12'hFAC;
    tick(); idle();
    chk("fillB_flags", {24'h0, flags}, 32'hFF);
    chk("fillB_irq0", {31'h0, irq0}, 32'h1);
    chk("fillB_irq1", {31'h0, irq1}, 32'h1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    chk("arst_flags", {24'h0, flags}, 32'h00);
    chk("arst_irq0", {31'h0, irq0}, 32'h0);
    chk("arst_irq1", {31'h0, irq1}, 32'h0);
    tick();
    reset = 1'b0;

    // INTE0 was cleared by reset: flag 0 sets without irq0
    sm_irq_vld = 4'b0001; sm_irq_idx = 12'h000;
    tick(); idle();
    chk("post_flags", {24'h0, flags}, 32'h01);
    chk("post_irq0", {31'h0, irq0}, 32'h0);

`ifdef PIO_IRQ_FORCE_EN
    // Force irq1 with INTE1=0 and flags=0
    host_wr_irq = 1'b1; host_din = 32'hFF;
    tick(); idle();
    host_din = 32'h8; host_wr_intf1 = 1'b1;
    tick(); idle();
    chk("intf1_flags", {24'h0, flags}, 32'h00);
    chk("intf1_irq1", {31'h0, irq1}, 32'h1);
    chk("intf1_irq0", {31'h0, irq0}, 32'h0);
    host_din = 32'h0; host_wr_intf1 = 1'b1;
    tick(); idle();
    chk("intf1off_irq1", {31'h0, irq1}, 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
